// File: rtl/fpga_io_ctrl_if.sv
// Wishbone slave bus bundle for the pad controller; signal names follow the
// Caravel user-project Wishbone port names.
interface fpga_io_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/fpga_io_ctrl.sv
// Wishbone-mapped pad controller: drives io_out/io_oeb, synchronises io_in for
// the fabric, and latches sticky rising edges with a level interrupt.
module fpga_io_ctrl #(
  parameter int          NUM_IO      = 38,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_1000,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hF250_0001
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  fpga_io_ctrl_if.slave     wb,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic [NUM_IO-1:0] fabric_in,
  output logic              irq_o
);

  localparam logic [5:0] W_OEB_LO = 6'd0,  W_OEB_HI = 6'd1;
  localparam logic [5:0] W_OUT_LO = 6'd2,  W_OUT_HI = 6'd3;
  localparam logic [5:0] W_IN_LO  = 6'd4,  W_IN_HI  = 6'd5;
  localparam logic [5:0] W_EDG_LO = 6'd6,  W_EDG_HI = 6'd7;
  localparam logic [5:0] W_IEN_LO = 6'd8,  W_IEN_HI = 6'd9;
  localparam logic [5:0] W_CTRL   = 6'd10, W_ID     = 6'd11;

  logic                                 ack_q, ack_d;
  logic [31:0]                          dat_q, dat_d;
  logic [NUM_IO-1:0]                    oeb_q, oeb_d;
  logic [NUM_IO-1:0]                    out_q, out_d;
  logic [NUM_IO-1:0]                    edge_q, edge_d;
  logic [NUM_IO-1:0]                    ien_q, ien_d;
  logic [NUM_IO-1:0]                    prev_q, prev_d;
  logic                                 fab_en_q, fab_en_d;
  logic                                 irq_q, irq_d;
  logic [SYNC_STAGES-1:0][NUM_IO-1:0]   sync_q, sync_d;

  logic              hit, wr, rd;
  logic [5:0]        word;
  logic [31:0]       bmask, rdata;
  logic [63:0]       wdat64, oeb_wen, out_wen, ien_wen, edg_wen;
  logic [63:0]       oeb_x, out_x, in_x, edge_x, ien_x;
  logic [NUM_IO-1:0] sync, rise, edge_clr;
  logic              unused_adr;

  // Expands a LO/HI register pair's byte mask into a 64-bit per-bit enable.
  function automatic logic [63:0] pair_en(input logic lo, input logic hi,
                                          input logic [31:0] m);
    return {(hi ? m : 32'h0), (lo ? m : 32'h0)};
  endfunction

  function automatic logic [63:0] zext(input logic [NUM_IO-1:0] v);
    logic [63:0] r;
    r = '0;
    r[NUM_IO-1:0] = v;
    return r;
  endfunction

  assign sync       = sync_q[SYNC_STAGES-1];
  assign unused_adr = &{1'b0, wb.wbs_adr_i[1:0]};

  always_comb begin
    hit    = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q &
             (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    wr     = hit & wb.wbs_we_i;
    rd     = hit & ~wb.wbs_we_i;
    word   = wb.wbs_adr_i[7:2];
    bmask  = {{8{wb.wbs_sel_i[3]}}, {8{wb.wbs_sel_i[2]}},
              {8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}};
    wdat64 = {wb.wbs_dat_i, wb.wbs_dat_i};

    oeb_wen = pair_en(wr && word == W_OEB_LO, wr && word == W_OEB_HI, bmask);
    out_wen = pair_en(wr && word == W_OUT_LO, wr && word == W_OUT_HI, bmask);
    ien_wen = pair_en(wr && word == W_IEN_LO, wr && word == W_IEN_HI, bmask);
    edg_wen = pair_en(wr && word == W_EDG_LO, wr && word == W_EDG_HI, bmask);

    // Bits above NUM_IO fall off in the slice, so HI writes ignore them.
    oeb_d = (oeb_q & ~oeb_wen[NUM_IO-1:0]) | (wdat64[NUM_IO-1:0] & oeb_wen[NUM_IO-1:0]);
    out_d = (out_q & ~out_wen[NUM_IO-1:0]) | (wdat64[NUM_IO-1:0] & out_wen[NUM_IO-1:0]);
    ien_d = (ien_q & ~ien_wen[NUM_IO-1:0]) | (wdat64[NUM_IO-1:0] & ien_wen[NUM_IO-1:0]);

    fab_en_d = fab_en_q;
    if (wr && word == W_CTRL && wb.wbs_sel_i[0]) fab_en_d = wb.wbs_dat_i[0];

    sync_d[0] = io_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d = sync;
    rise   = sync & ~prev_q;

    // Rise is OR'd after the clear so a same-cycle set wins over W1C.
    edge_clr = edg_wen[NUM_IO-1:0] & wdat64[NUM_IO-1:0];
    edge_d   = (edge_q & ~edge_clr) | rise;
    irq_d    = |(edge_q & ien_q);

    oeb_x  = zext(oeb_q);
    out_x  = zext(out_q);
    in_x   = zext(sync);
    edge_x = zext(edge_q);
    ien_x  = zext(ien_q);

    rdata = 32'h0;
    case (word)
      W_OEB_LO: rdata = oeb_x[31:0];
      W_OEB_HI: rdata = oeb_x[63:32];
      W_OUT_LO: rdata = out_x[31:0];
      W_OUT_HI: rdata = out_x[63:32];
      W_IN_LO:  rdata = in_x[31:0];
      W_IN_HI:  rdata = in_x[63:32];
      W_EDG_LO: rdata = edge_x[31:0];
      W_EDG_HI: rdata = edge_x[63:32];
      W_IEN_LO: rdata = ien_x[31:0];
      W_IEN_HI: rdata = ien_x[63:32];
      W_CTRL:   rdata = {31'h0, fab_en_q};
      W_ID:     rdata = ID_VALUE;
      default:  rdata = 32'h0;
    endcase

    ack_d = hit;
    dat_d = rd ? rdata : 32'h0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'h0;
      oeb_q    <= '1;
      out_q    <= '0;
      edge_q   <= '0;
      ien_q    <= '0;
      prev_q   <= '0;
      fab_en_q <= 1'b0;
      irq_q    <= 1'b0;
      sync_q   <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      oeb_q    <= oeb_d;
      out_q    <= out_d;
      edge_q   <= edge_d;
      ien_q    <= ien_d;
      prev_q   <= prev_d;
      fab_en_q <= fab_en_d;
      irq_q    <= irq_d;
      sync_q   <= sync_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign io_oeb       = oeb_q;
  assign io_out       = out_q;
  assign fabric_in    = fab_en_q ? sync : '0;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_fpga_io_ctrl.sv
// Directed-vector bench for fpga_io_ctrl: each task drives one scenario and
// compares against hand-computed values.
module tb_fpga_io_ctrl;
  localparam int          NUM_IO = 38;
  localparam logic [31:0] BASE   = 32'h3000_1000;
  localparam logic [31:0] ID     = 32'hF250_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpga_io_ctrl_if wb_bus ();
  logic [NUM_IO-1:0] io_in, io_out, io_oeb, fabric_in;
  logic              irq;

  int vectors     = 0;
  int miscompares = 0;

  fpga_io_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb        (wb_bus),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .fabric_in (fabric_in),
    .irq_o     (irq)
  );

  task automatic bus_idle();
    wb_bus.wbs_stb_i = 1'b0;
    wb_bus.wbs_cyc_i = 1'b0;
    wb_bus.wbs_we_i  = 1'b0;
    wb_bus.wbs_sel_i = 4'h0;
    wb_bus.wbs_dat_i = 32'h0;
    wb_bus.wbs_adr_i = 32'h0;
  endtask

  task automatic bus_drive(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
    wb_bus.wbs_stb_i = 1'b1;
    wb_bus.wbs_cyc_i = 1'b1;
    wb_bus.wbs_we_i  = we;
    wb_bus.wbs_sel_i = sel;
    wb_bus.wbs_dat_i = dat;
    wb_bus.wbs_adr_i = adr;
  endtask

  // One Wishbone access; lat = cycles from request to ack, -1 on timeout.
  task automatic wb_access(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           output logic [31:0] rdat, output int lat);
    @(posedge clk); #1;
    bus_drive(we, adr, dat, sel);
    lat  = -1;
    rdat = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (wb_bus.wbs_ack_o) begin
        lat  = i;
        rdat = wb_bus.wbs_dat_o;
        break;
      end
    end
    bus_idle();
  endtask

  task automatic check_read(input string name, input logic [31:0] adr,
                            input logic [31:0] exp);
    logic [31:0] d;
    int          lat;
    wb_access(1'b0, adr, 32'h0, 4'hF, d, lat);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL %s ack latency got %0d want 1", name, lat);
    end
    vectors++;
    if (d !== exp) begin
      miscompares++;
      $display("FAIL %s data got %08h want %08h", name, d, exp);
    end
  endtask

  task automatic do_write(input string name, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d;
    int          lat;
    wb_access(1'b1, adr, dat, sel, d, lat);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL %s write ack latency got %0d want 1", name, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_idle();
    io_in = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({wb_bus.wbs_ack_o, wb_bus.wbs_dat_o, irq} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_bus ack/dat/irq got %0b/%08h/%0b want 0/00000000/0",
               wb_bus.wbs_ack_o, wb_bus.wbs_dat_o, irq);
    end
    vectors++;
    if (io_oeb !== {NUM_IO{1'b1}} || io_out !== '0 || fabric_in !== '0) begin
      miscompares++;
      $display("FAIL reset_pads oeb/out/fab got %h/%h/%h want all1/0/0",
               io_oeb, io_out, fabric_in);
    end
    rst = 1'b0;
    check_read("rd_id",     BASE + 32'h2C, ID);
    check_read("rd_oeb_lo", BASE + 32'h00, 32'hFFFF_FFFF);
    check_read("rd_oeb_hi", BASE + 32'h04, 32'h0000_003F);
    check_read("rd_unmapped", BASE + 32'h30, 32'h0);
  endtask

  task automatic test_byte_write();
    do_write("wr_out_lo", BASE + 32'h08, 32'hA5A5_A5A5, 4'b0011);
    check_read("rd_out_lo", BASE + 32'h08, 32'h0000_A5A5);
    vectors++;
    if (io_out[31:0] !== 32'h0000_A5A5) begin
      miscompares++;
      $display("FAIL io_out_lo got %08h want 0000a5a5", io_out[31:0]);
    end
    do_write("wr_out_hi", BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF);
    check_read("rd_out_hi", BASE + 32'h0C, 32'h0000_003F);
    do_write("wr_out_hi0", BASE + 32'h0C, 32'h0, 4'hF);
  endtask

  task automatic test_window();
    int acks = 0;
    @(posedge clk); #1;
    bus_drive(1'b1, 32'h3000_2000, 32'hFFFF_FFFF, 4'hF);
    repeat (5) begin
      @(posedge clk); #1;
      if (wb_bus.wbs_ack_o) acks++;
    end
    bus_drive(1'b1, 32'h3000_2008, 32'hFFFF_FFFF, 4'hF);
    repeat (5) begin
      @(posedge clk); #1;
      if (wb_bus.wbs_ack_o) acks++;
    end
    bus_idle();
    vectors++;
    if (acks !== 0) begin
      miscompares++;
      $display("FAIL out_of_window acks got %0d want 0", acks);
    end
    check_read("rd_out_lo_kept", BASE + 32'h08, 32'h0000_A5A5);
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    bus_drive(1'b0, BASE + 32'h2C, 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (wb_bus.wbs_ack_o !== ((i % 2) == 0)) begin
        miscompares++;
        $display("FAIL held_stb_ack[%0d] got %0b want %0b", i,
                 wb_bus.wbs_ack_o, (i % 2) == 0);
      end
    end
    bus_idle();
  endtask

  task automatic test_edge_irq();
    do_write("wr_ctrl",   BASE + 32'h28, 32'h1, 4'hF);
    do_write("wr_ien_hi", BASE + 32'h24, 32'h1, 4'hF);
    check_read("rd_ctrl", BASE + 32'h28, 32'h1);
    io_in[32] = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (fabric_in[32] !== 1'b0) begin
      miscompares++;
      $display("FAIL fab_early got %0b want 0", fabric_in[32]);
    end
    @(posedge clk); #1;
    vectors++;
    if (fabric_in[32] !== 1'b1 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL fab_sync fab/irq got %0b/%0b want 1/0", fabric_in[32], irq);
    end
    @(posedge clk); #1;
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_edge_cycle got %0b want 0", irq);
    end
    @(posedge clk); #1;
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_rise got %0b want 1", irq);
    end
    check_read("rd_in_hi",   BASE + 32'h14, 32'h1);
    check_read("rd_edge_hi", BASE + 32'h1C, 32'h1);
    do_write("w1c_edge_hi", BASE + 32'h1C, 32'h1, 4'b0001);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_hold_on_clear got %0b want 1", irq);
    end
    @(posedge clk); #1;
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_drop got %0b want 0", irq);
    end
    check_read("rd_edge_hi_clr", BASE + 32'h1C, 32'h0);
  endtask

  task automatic test_set_wins();
    io_in[5] = 1'b1;
    @(posedge clk);
    // Rise of bit 5 is visible exactly on the W1C commit edge.
    do_write("w1c_race", BASE + 32'h18, 32'h0000_0020, 4'hF);
    check_read("rd_edge_lo_set", BASE + 32'h18, 32'h0000_0020);
    do_write("w1c_lo", BASE + 32'h18, 32'h0000_0020, 4'hF);
    check_read("rd_edge_lo_clr", BASE + 32'h18, 32'h0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus_drive(1'b1, BASE + 32'h00, 32'h0, 4'hF);
    @(posedge clk); #1;
    vectors++;
    if (wb_bus.wbs_ack_o !== 1'b1 || io_oeb[31:0] !== 32'h0) begin
      miscompares++;
      $display("FAIL oeb_write ack/oeb got %0b/%08h want 1/00000000",
               wb_bus.wbs_ack_o, io_oeb[31:0]);
    end
    rst = 1'b1;
    bus_idle();
    @(posedge clk); #1;
    vectors++;
    if (wb_bus.wbs_ack_o !== 1'b0 || io_oeb !== {NUM_IO{1'b1}} || io_out !== '0) begin
      miscompares++;
      $display("FAIL reset_mid ack/oeb/out got %0b/%h/%h want 0/all1/0",
               wb_bus.wbs_ack_o, io_oeb, io_out);
    end
    rst = 1'b0;
    check_read("rd_oeb_after_rst", BASE + 32'h00, 32'hFFFF_FFFF);
    check_read("rd_ctrl_after_rst", BASE + 32'h28, 32'h0);
  endtask

  initial begin
    bus_idle();
    io_in = '0;
    test_reset();
    test_byte_write();
    test_window();
    test_back_to_back();
    test_edge_irq();
    test_set_wins();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
